// File: rtl/riscv_pkg.sv
// Shared format codes, NOP word and opcode constants for the instruction encoder.
// Optional immediate range checking is enabled with RISCV_ENC_RANGE_CHECK_EN.
package riscv_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_J = 3'd3,
        FMT_U = 3'd4,
        FMT_R = 3'd5
    } fmt_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_OP     = 7'h33;

    function automatic logic fmt_reserved(input logic [2:0] fmt);
        return fmt > FMT_R;
    endfunction

endpackage

// File: rtl/riscv_imm_pack.sv
// Combinational packing of register/function fields and immediate into a word.
// Range errors are only computed when RISCV_ENC_RANGE_CHECK_EN is defined.
module riscv_imm_pack
    import riscv_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        range_err
);

    always_comb begin
        inst = NOP_INST;
        case (fmt)
            FMT_I: inst = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: inst = {imm[12], imm[10:5], rs2, rs1, funct3,
                           imm[4:1], imm[11], opcode};
            FMT_J: inst = {imm[20], imm[10:1], imm[11], imm[19:12],
                           rd, opcode};
            FMT_U: inst = {imm[31:12], rd, opcode};
            FMT_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
            default: inst = NOP_INST;
        endcase
    end

`ifdef RISCV_ENC_RANGE_CHECK_EN
    // Upper bits must be a pure sign extension of the encodable field.
    logic sx_is, sx_b, sx_j;

    assign sx_is = !(&imm[31:11] || ~|imm[31:11]);
    assign sx_b  = !(&imm[31:12] || ~|imm[31:12]);
    assign sx_j  = !(&imm[31:20] || ~|imm[31:20]);

    always_comb begin
        range_err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_err = sx_is;
            FMT_B:        range_err = sx_b | imm[0];
            FMT_J:        range_err = sx_j | imm[0];
            FMT_U:        range_err = |imm[11:0];
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: rtl/riscv_inst_encoder.sv
// Instruction encoder: valid/ready request in, registered word plus byte address out.
// RISCV_ENC_RANGE_CHECK_EN adds immediate range errors to out_err.
module riscv_inst_encoder
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic        addr_load,
    input  logic [31:0] addr_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        out_err
);

    logic [31:0] next_addr;
    logic [31:0] base_al;
    logic [31:0] cur_addr;
    logic [31:0] pack_inst;
    logic        pack_err;
    logic        accept;
    logic        rsvd;

    riscv_imm_pack u_pack (
        .fmt       (in_fmt),
        .opcode    (in_opcode),
        .funct3    (in_funct3),
        .funct7    (in_funct7),
        .rd        (in_rd),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .imm       (in_imm),
        .inst      (pack_inst),
        .range_err (pack_err)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign rsvd     = fmt_reserved(in_fmt);
    assign base_al  = addr_base & 32'hFFFF_FFFC;
    // A coincident load redirects the request being accepted this cycle.
    assign cur_addr = addr_load ? base_al : next_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_addr  <= '0;
            out_err   <= 1'b0;
            next_addr <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_inst  <= pack_inst;
            out_err   <= rsvd | pack_err;
            out_addr  <= cur_addr;
            next_addr <= cur_addr + 32'd4;
        end else begin
            if (out_ready)
                out_valid <= 1'b0;
            if (addr_load)
                next_addr <= base_al;
        end
    end

endmodule

// File: tb/tb_riscv_inst_encoder.sv
// Directed table-driven bench for riscv_inst_encoder plus backpressure,
// address wrap and mid-stream reset sequences.
module tb_riscv_inst_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        addr_load;
    logic [31:0] addr_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;

    riscv_inst_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .addr_load (addr_load),
        .addr_base (addr_base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RISCV_ENC_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_run;
    int   n_fail;
    logic [31:0] exp_addr;
    logic [31:0] hold_inst;
    logic [31:0] hold_addr;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid  = 1'b1;
        in_fmt    = v.fmt;
        in_opcode = v.op;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_imm    = v.imm;
    endtask

    function automatic vec_t addi(input logic [31:0] imm, input logic [31:0] ex);
        vec_t v;
        v = '{"addi", 3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, imm, ex, 1'b0};
        return v;
    endfunction

    initial begin
        n_run     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_fmt    = '0;
        in_opcode = '0;
        in_funct3 = '0;
        in_funct7 = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm    = '0;
        addr_load = 1'b0;
        addr_base = '0;
        out_ready = 1'b1;

        vecs.push_back('{"addi5", 3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
                         32'd5, 32'h0050_0093, 1'b0});
        vecs.push_back('{"sw", 3'd1, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2,
                         32'd8, 32'h0020_A423, 1'b0});
        vecs.push_back('{"beq-4", 3'd2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
                         32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0});
        vecs.push_back('{"jal", 3'd3, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
                         32'h0000_0800, 32'h0010_00EF, 1'b0});
        vecs.push_back('{"lui", 3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0,
                         32'h1234_5000, 32'h1234_52B7, 1'b0});
        vecs.push_back('{"sub", 3'd5, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3,
                         32'd0, 32'h4031_00B3, 1'b0});
        vecs.push_back('{"fmt7", 3'd7, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3,
                         32'd0, 32'h0000_0013, 1'b1});
        vecs.push_back('{"fmt6", 3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
                         32'd5, 32'h0000_0013, 1'b1});
        vecs.push_back('{"addi2048", 3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
                         32'd2048, 32'h8000_0093, RC});
        vecs.push_back('{"beq6", 3'd2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
                         32'd6, 32'h0000_0363, 1'b0});
        vecs.push_back('{"beq3", 3'd2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
                         32'd3, 32'h0000_0163, RC});
        vecs.push_back('{"addi-1", 3'd0, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
                         32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0});
        vecs.push_back('{"lui-lo", 3'd4, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
                         32'h0000_1001, 32'h0000_10B7, RC});

        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_inst", out_inst, 32'd0);
        check("rst_addr", out_addr, 32'd0);
        check("rst_err", {31'd0, out_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back table, base loaded with low bits set.
        exp_addr = 32'h0000_1000;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            addr_load = (i == 0);
            addr_base = 32'h0000_1003;
            step();
            check({vecs[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
            check({vecs[i].name, "_inst"}, out_inst, vecs[i].exp_inst);
            check({vecs[i].name, "_err"}, {31'd0, out_err},
                  {31'd0, vecs[i].exp_err});
            check({vecs[i].name, "_addr"}, out_addr, exp_addr);
            exp_addr = exp_addr + 32'd4;
        end
        in_valid  = 1'b0;
        addr_load = 1'b0;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: hold A for 3 cycles while B waits.
        out_ready = 1'b0;
        drive(addi(32'd1, 32'h0010_0093));
        step();
        check("bp_a_valid", {31'd0, out_valid}, 32'd1);
        hold_inst = 32'h0010_0093;
        hold_addr = exp_addr;
        drive(addi(32'd2, 32'h0020_0093));
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold_inst", out_inst, hold_inst);
            check("bp_hold_addr", out_addr, hold_addr);
        end
        out_ready = 1'b1;
        step();
        check("bp_b_inst", out_inst, 32'h0020_0093);
        check("bp_b_addr", out_addr, hold_addr + 32'd4);
        in_valid = 1'b0;
        step();
        check("bp_done_valid", {31'd0, out_valid}, 32'd0);

        // Load without acceptance, then use it.
        addr_load = 1'b1;
        addr_base = 32'h0000_2000;
        step();
        addr_load = 1'b0;
        drive(addi(32'd5, 32'h0050_0093));
        step();
        check("ld_idle_addr", out_addr, 32'h0000_2000);

        // Address wrap.
        addr_load = 1'b1;
        addr_base = 32'hFFFF_FFF8;
        step();
        check("wrap0", out_addr, 32'hFFFF_FFF8);
        addr_load = 1'b0;
        step();
        check("wrap1", out_addr, 32'hFFFF_FFFC);
        step();
        check("wrap2", out_addr, 32'h0000_0000);

        // Reset mid-stream while stalled.
        out_ready = 1'b0;
        step();
        check("mr_valid_pre", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_valid", {31'd0, out_valid}, 32'd0);
        check("mr_addr", out_addr, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        drive(addi(32'd5, 32'h0050_0093));
        step();
        check("mr_first_addr", out_addr, 32'd0);
        check("mr_first_inst", out_inst, 32'h0050_0093);
        in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
